// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - per-frame Flappy Bird sequencer: state machine, bird physics, pipe scroll, score
module flappy_game_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BIRD_X      = 140,
    parameter int BIRD_W      = 20,
    parameter int BIRD_H      = 20,
    parameter int Y_START     = 240,
    parameter int GRAVITY     = 1,
    parameter int FLAP_V      = 8,
    parameter int VMAX        = 10,
    parameter int PIPE_W      = 40,
    parameter int PIPE_SPEED  = 2,
    parameter int GAP_H       = 120,
    parameter int GAP_MIN     = 64,
    parameter int GAP_INIT    = 180,
    parameter int DEAD_FRAMES = 60
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       frame_tick,
    input  logic       flap,
    output logic [1:0] game_state,
    output logic [9:0] bird_y,
    output logic [9:0] pipe_x,
    output logic [8:0] gap_y,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [9:0]         X_RESET = 10'(SCREEN_W);
    localparam logic [9:0]         Y_INIT  = 10'(Y_START);
    localparam logic [9:0]         Y_BOT   = 10'(SCREEN_H - BIRD_H);
    localparam logic signed [10:0] NY_BOT  = 11'(SCREEN_H - BIRD_H);
    localparam logic signed [7:0]  V_FLAP  = 8'(-FLAP_V);
    localparam logic signed [7:0]  V_MAX   = 8'(VMAX);
    localparam logic signed [7:0]  V_GRAV  = 8'(GRAVITY);
    localparam logic [9:0]         P_SPEED = 10'(PIPE_SPEED);
    localparam logic [10:0]        P_W     = 11'(PIPE_W);
    localparam logic [10:0]        B_XL    = 11'(BIRD_X);
    localparam logic [10:0]        B_XR    = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0]        B_H     = 11'(BIRD_H);
    localparam logic [10:0]        G_H     = 11'(GAP_H);
    localparam logic [8:0]         G_MIN   = 9'(GAP_MIN);
    localparam logic [8:0]         G_INIT  = 9'(GAP_INIT);
    localparam logic [7:0]         D_LIM   = 8'(DEAD_FRAMES);

    state_t             state_q, state_d;
    logic [9:0]         bird_q, bird_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [9:0]         pipe_q, pipe_d;
    logic [8:0]         gap_q, gap_d;
    logic [7:0]         score_q, score_d;
    logic [7:0]         dead_q, dead_d;
    logic               pend_q, pend_d;
    logic               flap_q;
    logic [15:0]        lfsr_q;

    logic               flap_edge, flap_now;
    logic signed [7:0]  vel_sum, vel_calc;
    logic signed [10:0] ny;
    logic [9:0]         bird_new, pipe_new;
    logic [8:0]         gap_new;
    logic               pipe_wrap, hit_edge, x_overlap, out_of_gap, die;

    // Candidate next-frame values, shared by the IDLE launch and PLAY ticks.
    always_comb begin
        flap_edge = flap & ~flap_q;
        flap_now  = pend_q | flap_edge;
        vel_sum   = vel_q + V_GRAV;
        if (flap_now)
            vel_calc = V_FLAP;
        else if (vel_sum > V_MAX)
            vel_calc = V_MAX;
        else
            vel_calc = vel_sum;

        ny       = $signed({1'b0, bird_q}) + $signed({{3{vel_calc[7]}}, vel_calc});
        hit_edge = 1'b0;
        bird_new = ny[9:0];
        if (ny <= 11'sd0) begin
            bird_new = 10'd0;
            hit_edge = 1'b1;
        end else if (ny >= NY_BOT) begin
            bird_new = Y_BOT;
            hit_edge = 1'b1;
        end

        pipe_wrap = pipe_q < P_SPEED;
        pipe_new  = pipe_wrap ? X_RESET : pipe_q - P_SPEED;
        gap_new   = pipe_wrap ? G_MIN + {1'b0, lfsr_q[7:0]} : gap_q;

        x_overlap  = (B_XL < {1'b0, pipe_new} + P_W) && ({1'b0, pipe_new} < B_XR);
        out_of_gap = ({1'b0, bird_new} < {2'b0, gap_new}) ||
                     ({1'b0, bird_new} + B_H > {2'b0, gap_new} + G_H);
        die        = hit_edge || (x_overlap && out_of_gap);
    end

    always_comb begin
        state_d = state_q;
        bird_d  = bird_q;
        vel_d   = vel_q;
        pipe_d  = pipe_q;
        gap_d   = gap_q;
        score_d = score_q;
        dead_d  = dead_q;
        pend_d  = pend_q | flap_edge;
        if (frame_tick) begin
            pend_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flap_now) begin
                        state_d = ST_PLAY;
                        score_d = 8'd0;
                        vel_d   = vel_calc;
                        bird_d  = bird_new;
                    end
                end
                ST_PLAY: begin
                    vel_d  = vel_calc;
                    bird_d = bird_new;
                    pipe_d = pipe_new;
                    gap_d  = gap_new;
                    if (die) begin
                        state_d = ST_DEAD;
                        dead_d  = 8'd0;
                    end else if (pipe_wrap && score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                end
                ST_DEAD: begin
                    if (dead_q < D_LIM) begin
                        dead_d = dead_q + 8'd1;
                    end else if (flap_now) begin
                        state_d = ST_IDLE;
                        bird_d  = Y_INIT;
                        vel_d   = 8'sd0;
                        pipe_d  = X_RESET;
                        gap_d   = G_INIT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            bird_q  <= Y_INIT;
            vel_q   <= 8'sd0;
            pipe_q  <= X_RESET;
            gap_q   <= G_INIT;
            score_q <= 8'd0;
            dead_q  <= 8'd0;
            pend_q  <= 1'b0;
            flap_q  <= 1'b0;
            lfsr_q  <= 16'hACE1;
        end else begin
            state_q <= state_d;
            bird_q  <= bird_d;
            vel_q   <= vel_d;
            pipe_q  <= pipe_d;
            gap_q   <= gap_d;
            score_q <= score_d;
            dead_q  <= dead_d;
            pend_q  <= pend_d;
            flap_q  <= flap;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign game_state = state_q;
    assign bird_y     = bird_q;
    assign pipe_x     = pipe_q;
    assign gap_y      = gap_q;
    assign score      = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - directed self-checking bench for flappy_game_ctrl
module tb_flappy_game_ctrl;

    logic       dclk;
    logic       clr_n;
    logic       frame_tick;
    logic       flap;
    logic [1:0] game_state;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;
    logic [8:0] gap_y;
    logic [7:0] score;

    int          n_checks;
    int          n_errors;
    logic [15:0] m_lfsr;
    logic [15:0] tick_lfsr;

    flappy_game_ctrl dut (
        .dclk       (dclk),
        .clr_n      (clr_n),
        .frame_tick (frame_tick),
        .flap       (flap),
        .game_state (game_state),
        .bird_y     (bird_y),
        .pipe_x     (pipe_x),
        .gap_y      (gap_y),
        .score      (score)
    );

    initial dclk = 1'b0;
    always #20 dclk = ~dclk;

    // Reference LFSR: seed and taps from the block description, free-running like the design.
    always @(posedge dclk or negedge clr_n) begin
        if (!clr_n)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input bit with_flap);
        @(negedge dclk);
        frame_tick = 1'b1;
        if (with_flap) flap = 1'b1;
        tick_lfsr = m_lfsr;
        @(negedge dclk);
        frame_tick = 1'b0;
        flap       = 1'b0;
    endtask

    task automatic flap_pulse();
        @(negedge dclk);
        flap = 1'b1;
        @(negedge dclk);
        flap = 1'b0;
        @(negedge dclk);
    endtask

    task automatic do_reset();
        @(negedge dclk);
        clr_n = 1'b0;
        repeat (2) @(negedge dclk);
        clr_n = 1'b1;
        @(negedge dclk);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_state"}, 32'(game_state), 32'd0);
        check_eq({tag, "_bird"},  32'(bird_y),     32'd240);
        check_eq({tag, "_pipe"},  32'(pipe_x),     32'd640);
        check_eq({tag, "_gap"},   32'(gap_y),      32'd180);
        check_eq({tag, "_score"}, 32'(score),      32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        clr_n      = 1'b0;
        frame_tick = 1'b0;
        flap       = 1'b0;
        tick_lfsr  = 16'h0;
        repeat (3) @(negedge dclk);
        check_idle("rst");
        clr_n = 1'b1;

        repeat (3) tick(1'b0);
        check_idle("idle3");

        // Launch with the flap edge on the tick itself, then free fall to the floor.
        tick(1'b1);
        check_eq("launch_state", 32'(game_state), 32'd1);
        check_eq("launch_bird",  32'(bird_y),     32'd232);
        check_eq("launch_pipe",  32'(pipe_x),     32'd640);
        for (int t = 1; t <= 39; t++) begin
            tick(1'b0);
            case (t)
                1:  check_eq("fall_t1",  32'(bird_y), 32'd225);
                16: check_eq("fall_t16", 32'(bird_y), 32'd240);
                18: check_eq("fall_t18", 32'(bird_y), 32'd259);
                19: check_eq("fall_cap", 32'(bird_y), 32'd269);
                38: begin
                    check_eq("fall_t38_bird",  32'(bird_y),     32'd459);
                    check_eq("fall_t38_state", 32'(game_state), 32'd1);
                end
                39: begin
                    check_eq("floor_bird",  32'(bird_y),     32'd460);
                    check_eq("floor_state", 32'(game_state), 32'd2);
                    check_eq("floor_pipe",  32'(pipe_x),     32'd562);
                end
                default: ;
            endcase
        end
        tick(1'b0);
        check_eq("dead_frz_bird", 32'(bird_y), 32'd460);
        check_eq("dead_frz_pipe", 32'(pipe_x), 32'd562);

        // Scroll run: two flap edges in one frame count once; flap every 17 ticks keeps bird in 204..240.
        do_reset();
        flap_pulse();
        flap_pulse();
        tick(1'b0);
        check_eq("pend_bird", 32'(bird_y), 32'd232);
        for (int t = 1; t <= 321; t++) begin
            tick((t % 17) == 0);
            case (t)
                100: check_eq("scroll_t100", 32'(pipe_x), 32'd440);
                241: begin
                    check_eq("pass_state", 32'(game_state), 32'd1);
                    check_eq("pass_pipe",  32'(pipe_x),     32'd158);
                    check_eq("pass_bird",  32'(bird_y),     32'd214);
                end
                320: begin
                    check_eq("edge_pipe",  32'(pipe_x),     32'd0);
                    check_eq("edge_state", 32'(game_state), 32'd1);
                end
                321: begin
                    check_eq("wrap_pipe",  32'(pipe_x),     32'd640);
                    check_eq("wrap_score", 32'(score),      32'd1);
                    check_eq("wrap_gap",   32'(gap_y),      32'd64 + 32'(tick_lfsr[7:0]));
                    check_eq("wrap_bird",  32'(bird_y),     32'd232);
                    check_eq("wrap_state", 32'(game_state), 32'd1);
                end
                default: ;
            endcase
        end

        // Asynchronous reset between ticks, sampled before any clock edge.
        repeat (3) @(negedge dclk);
        clr_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge dclk);
        clr_n = 1'b1;
        tick(1'b0);
        check_eq("post_rst_state", 32'(game_state), 32'd0);

        // Pipe death: rise out of the gap just as the pipe reaches the bird.
        tick(1'b1);
        for (int t = 1; t <= 241; t++) begin
            tick(((t % 17) == 0) || (t >= 230));
            case (t)
                229: check_eq("rise_t229", 32'(bird_y), 32'd204);
                240: begin
                    check_eq("rise_t240_state", 32'(game_state), 32'd1);
                    check_eq("rise_t240_bird",  32'(bird_y),     32'd116);
                end
                241: begin
                    check_eq("hit_state", 32'(game_state), 32'd2);
                    check_eq("hit_bird",  32'(bird_y),     32'd108);
                    check_eq("hit_pipe",  32'(pipe_x),     32'd158);
                    check_eq("hit_score", 32'(score),      32'd0);
                    check_eq("hit_gap",   32'(gap_y),      32'd180);
                end
                default: ;
            endcase
        end

        for (int k = 1; k <= 60; k++) begin
            flap_pulse();
            tick(1'b0);
        end
        check_eq("dead60_state", 32'(game_state), 32'd2);
        check_eq("dead60_bird",  32'(bird_y),     32'd108);
        check_eq("dead60_pipe",  32'(pipe_x),     32'd158);
        tick(1'b0);
        check_eq("dead61_noflap", 32'(game_state), 32'd2);
        flap_pulse();
        tick(1'b0);
        check_idle("revive");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
